mult_sched: RTL

MULT_SCHED -- requirements
Module: mult_sched

---
 rtl/mult_sched.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mult_sched.sv
// -----------------------------------------------------------------------------
// mult_sched -- two-requester scheduler in front of a shared shift-add
// multiplier.
//
// A requester raises its Req with operands stable. In IDLE the scheduler picks
// a winner and latches that requester's operands into Mcand/Mplier. It then
// pulses St for one cycle and waits for Done. When Done arrives, or when
// TIMEOUT WAIT cycles have passed without it, the scheduler returns the result
// with a one-cycle Ack.
//
// Configuration macro: MULT_SCHED_RR_EN
//   defined   -> round-robin arbitration on simultaneous requests. The pointer
//                moves to the requester not served, on ACK entry.
//   undefined -> fixed priority; Req0 wins. No pointer exists.
//
// Parameters
//   W        operand width (product is 2*W)
//   TIMEOUT  WAIT cycles allowed before Done is declared missing
//
// Ports
//   Clk               system clock, rising edge
//   Rst               synchronous active-high reset
//   Req0/Req1         requests, held until Ack sampled
//   A0,B0,A1,B1       requester operands
//   Gnt0/Gnt1         grant, one-hot or zero, START..ACK inclusive
//   Ack0/Ack1         one-cycle completion strobe
//   P_out             product (0 on timeout), held until next ACK entry
//   Err               timeout flag, held until next ACK entry
//   St                one-cycle start pulse to the multiplier
//   Mcand/Mplier      registered operands to the multiplier
//   Done              multiplier completion (only honoured in WAIT)
//   Prod              multiplier product
// -----------------------------------------------------------------------------
module mult_sched #(
    parameter int W       = 4,
    parameter int TIMEOUT = 40
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [W-1:0]     A0,
    input  logic [W-1:0]     B0,
    input  logic [W-1:0]     A1,
    input  logic [W-1:0]     B1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             Ack0,
    output logic             Ack1,
    output logic [2*W-1:0]   P_out,
    output logic             Err,
    output logic             St,
    output logic [W-1:0]     Mcand,
    output logic [W-1:0]     Mplier,
    input  logic             Done,
    input  logic [2*W-1:0]   Prod
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          pick1_s;     // arbitration result: 1 selects requester 1
    logic          wait_end_s;  // WAIT finishes this cycle (Done or timeout)

`ifdef MULT_SCHED_RR_EN
    logic          rr_ptr_r;    // requester favoured on a tie (0 or 1)

    // Round-robin pick: the pointer only matters when both requesters are asking.
    always_comb begin
        pick1_s = 1'b0;
        if (Req0 && Req1) begin
            pick1_s = rr_ptr_r;
        end else if (Req1) begin
            pick1_s = 1'b1;
        end else begin
            pick1_s = 1'b0;
        end
    end
`else
    // Fixed-priority pick: requester 1 wins only when requester 0 is silent.
    always_comb begin
        pick1_s = 1'b0;
        if (Req1 && !Req0) begin
            pick1_s = 1'b1;
        end else begin
            pick1_s = 1'b0;
        end
    end
`endif

    // The last counted cycle ends WAIT even without Done. That gives exactly
    // TIMEOUT WAIT cycles.
    always_comb begin
        wait_end_s = 1'b0;
        if (state_r == WAIT) begin
            wait_end_s = Done || (cnt_r == CNT_LAST);
        end else begin
            wait_end_s = 1'b0;
        end
    end

    // Scheduler FSM; every output is a register updated here.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            Gnt0    <= 1'b0;
            Gnt1    <= 1'b0;
            Ack0    <= 1'b0;
            Ack1    <= 1'b0;
            St      <= 1'b0;
            Err     <= 1'b0;
            P_out   <= {(2*W){1'b0}};
            Mcand   <= {W{1'b0}};
            Mplier  <= {W{1'b0}};
`ifdef MULT_SCHED_RR_EN
            rr_ptr_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (Req0 || Req1) begin
                        Gnt0    <= !pick1_s;
                        Gnt1    <= pick1_s;
                        Mcand   <= pick1_s ? A1 : A0;
                        Mplier  <= pick1_s ? B1 : B0;
                        St      <= 1'b1;
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    St      <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                    state_r <= WAIT;
                end
                WAIT: begin
                    // Done takes precedence over a timeout in the same cycle.
                    if (Done) begin
                        P_out <= Prod;
                        Err   <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        P_out <= {(2*W){1'b0}};
                        Err   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                    if (wait_end_s) begin
                        Ack0    <= Gnt0;
                        Ack1    <= Gnt1;
                        state_r <= ACK;
`ifdef MULT_SCHED_RR_EN
                        // Favour whichever requester was not just served.
                        rr_ptr_r <= Gnt0;
`endif
                    end else begin
                        state_r <= WAIT;
                    end
                end
                ACK: begin
                    Ack0    <= 1'b0;
                    Ack1    <= 1'b0;
                    Gnt0    <= 1'b0;
                    Gnt1    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    Ack0    <= 1'b0;
                    Ack1    <= 1'b0;
                    Gnt0    <= 1'b0;
                    Gnt1    <= 1'b0;
                    St      <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
